// File: rtl/pt_check.sv
// Plaintext printability checker: scans the length-prefixed plaintext RAM and reports bad (non-printable) bytes.
// Optional build macro PT_CHECK_EARLY_EXIT_EN stops the scan at the first bad byte.
module pt_check (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic       ok,
    output logic [7:0] bad_count,
    output logic [7:0] first_bad
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RDLEN1 = 3'd1;
    localparam logic [2:0] S_RDLEN2 = 3'd2;
    localparam logic [2:0] S_RDB1   = 3'd3;
    localparam logic [2:0] S_RDB2   = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

`ifdef PT_CHECK_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    logic [2:0] state_q, state_d;
    logic [7:0] k_q, k_d;
    logic [7:0] mlen_q, mlen_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] bad_count_q, bad_count_d;
    logic [7:0] first_bad_q, first_bad_d;
    logic       ok_q, ok_d;
    logic       byte_bad;

    // Printable ASCII is 0x20..0x7E inclusive; everything else is bad.
    assign byte_bad = (byte_q < 8'h20) || (byte_q > 8'h7E);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        k_d         = k_q;
        mlen_d      = mlen_q;
        byte_d      = byte_q;
        bad_count_d = bad_count_q;
        first_bad_d = first_bad_q;
        ok_d        = ok_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d     = S_RDLEN1;
                    k_d         = 8'd1;
                    bad_count_d = 8'd0;
                    first_bad_d = 8'd0;
                    ok_d        = 1'b0;
                end
            end
            S_RDLEN1: state_d = S_RDLEN2;
            S_RDLEN2: begin
                mlen_d  = pt_rddata;
                state_d = (pt_rddata == 8'd0) ? S_DONE : S_RDB1;
            end
            S_RDB1: state_d = S_RDB2;
            S_RDB2: begin
                byte_d  = pt_rddata;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (byte_bad) begin
                    bad_count_d = bad_count_q + 8'd1;
                    if (first_bad_q == 8'd0) begin
                        first_bad_d = k_q;
                    end
                end
                // k stops at mlen (max 255), so the increment below never wraps.
                if ((k_q == mlen_q) || (EARLY_EXIT && byte_bad)) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = S_RDB1;
                end
            end
            S_DONE: begin
                ok_d    = (bad_count_q == 8'd0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= 8'd0;
            mlen_q      <= 8'd0;
            byte_q      <= 8'd0;
            bad_count_q <= 8'd0;
            first_bad_q <= 8'd0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mlen_q      <= mlen_d;
            byte_q      <= byte_d;
            bad_count_q <= bad_count_d;
            first_bad_q <= first_bad_d;
            ok_q        <= ok_d;
        end
    end

    // The RAM address is held for both read cycles of each byte; 0 otherwise.
    always_comb begin
        pt_addr = 8'd0;
        if ((state_q == S_RDB1) || (state_q == S_RDB2)) begin
            pt_addr = k_q;
        end
    end

    assign rdy       = (state_q == S_IDLE);
    assign ok        = ok_q;
    assign bad_count = bad_count_q;
    assign first_bad = first_bad_q;

endmodule

// File: tb/tb_pt_check.sv
// Self-checking bench for pt_check: a queue-based run model predicts every busy cycle and the held results.
// Build with PT_CHECK_EARLY_EXIT_EN defined to check the early-exit variant.
module tb_pt_check;

`ifdef PT_CHECK_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic       ok;
    logic [7:0] bad_count;
    logic [7:0] first_bad;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int runs_started = 0;

    always #5 clk = ~clk;

    pt_check dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ok        (ok),
        .bad_count (bad_count),
        .first_bad (first_bad)
    );

    // Synchronous-read plaintext RAM.
    always @(posedge clk) pt_rddata <= mem[pt_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected view of one busy cycle: address on the RAM port and the running result counters.
    typedef struct {
        logic [7:0] addr;
        logic [7:0] bc;
        logic [7:0] fb;
    } cyc_t;

    cyc_t       q[$];
    logic       e_ok = 1'b0, r_ok = 1'b0;
    logic [7:0] e_bc = 8'd0, e_fb = 8'd0, r_bc = 8'd0, r_fb = 8'd0;

    function automatic bit is_bad(input logic [7:0] b);
        return (b < 8'h20) || (b > 8'h7E);
    endfunction

    task automatic push(input int a, input int bc, input int fb);
        cyc_t c;
        c.addr = 8'(a);
        c.bc   = 8'(bc);
        c.fb   = 8'(fb);
        q.push_back(c);
    endtask

    // Model: on an accepted start, derive the whole run from the RAM contents.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            e_ok = 1'b0;
            e_bc = 8'd0;
            e_fb = 8'd0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                e_ok = r_ok;
                e_bc = r_bc;
                e_fb = r_fb;
            end
        end else if (en) begin
            int mlen, bc, fb, n;
            runs_started++;
            mlen = int'(mem[0]);
            bc = 0;
            fb = 0;
            n = mlen;
            push(0, 0, 0);
            push(0, 0, 0);
            for (int i = 1; i <= mlen; i++) begin
                push(i, bc, fb);
                push(i, bc, fb);
                push(0, bc, fb);
                if (is_bad(mem[i])) begin
                    bc++;
                    if (fb == 0) fb = i;
                    if (EARLY) begin
                        n = i;
                        break;
                    end
                end
            end
            push(0, bc, fb);
            r_ok = (bc == 0);
            r_bc = 8'(bc);
            r_fb = 8'(fb);
            if (n > 255) $display("model overrun");
        end
    end

    // Compare process: every cycle, busy or idle.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (q.size() > 0) begin
                check("busy_rdy", rdy, 1'b0);
                check("busy_ok", ok, 1'b0);
                check("busy_addr", pt_addr, q[0].addr);
                check("busy_bad_count", bad_count, q[0].bc);
                check("busy_first_bad", first_bad, q[0].fb);
            end else begin
                check("idle_rdy", rdy, 1'b1);
                check("idle_addr", pt_addr, 8'd0);
                check("idle_ok", ok, e_ok);
                check("idle_bad_count", bad_count, e_bc);
                check("idle_first_bad", first_bad, e_fb);
            end
        end
    end

    // Start a run at the next edge and count edges until rdy is high again.
    task automatic run(input bit glitch, output int edges);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        edges = 0;
        while (!rdy && edges < LIMIT) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (rdy) break;
            en = glitch && ($urandom_range(0, 3) == 0);
        end
        en = 1'b0;
        check("run_done", rdy, 1'b1);
    endtask

    task automatic load(input int mlen, input logic [7:0] bytes[$]);
        mem[0] = 8'(mlen);
        for (int i = 0; i < bytes.size(); i++) mem[i + 1] = bytes[i];
    endtask

    initial begin
        int edges;
        logic [7:0] b[$];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        check("rst_rdy", rdy, 1'b1);
        check("rst_ok", ok, 1'b0);
        check("rst_bad_count", bad_count, 8'd0);
        check("rst_first_bad", first_bad, 8'd0);
        check("rst_addr", pt_addr, 8'd0);

        // Empty message.
        mem[0] = 8'd0;
        run(1'b0, edges);
        check("empty_edges", edges, 3);
        check("empty_ok", ok, 1'b1);
        check("empty_bad_count", bad_count, 8'd0);

        // Clean three-byte message.
        b = '{8'h61, 8'h62, 8'h63};
        load(3, b);
        run(1'b0, edges);
        check("abc_edges", edges, 12);
        check("abc_ok", ok, 1'b1);
        check("abc_bad_count", bad_count, 8'd0);
        check("abc_first_bad", first_bad, 8'd0);

        // Mixed message with two bad bytes.
        b = '{8'h41, 8'h0A, 8'h42, 8'h7F};
        load(4, b);
        run(1'b0, edges);
        check("mixed_edges", edges, EARLY ? 9 : 15);
        check("mixed_ok", ok, 1'b0);
        check("mixed_bad_count", bad_count, EARLY ? 8'd1 : 8'd2);
        check("mixed_first_bad", first_bad, 8'd2);

        // Printable-range boundaries.
        b = '{8'h1F, 8'h20, 8'h7E, 8'h7F};
        load(4, b);
        run(1'b0, edges);
        check("bound_edges", edges, EARLY ? 6 : 15);
        check("bound_bad_count", bad_count, EARLY ? 8'd1 : 8'd2);
        check("bound_first_bad", first_bad, 8'd1);

        // Longest message: k must reach 255 without wrapping.
        mem[0] = 8'd255;
        for (int i = 1; i < 256; i++) mem[i] = 8'h78;
        run(1'b0, edges);
        check("max_edges", edges, 768);
        check("max_ok", ok, 1'b1);

        // Reset during the second read cycle of byte 5.
        mem[0] = 8'd8;
        for (int i = 1; i <= 8; i++) mem[i] = 8'h78;
        mem[3] = EARLY ? 8'h78 : 8'h05;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("pre_rst_addr", pt_addr, 8'd5);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_rdy", rdy, 1'b1);
        check("midrst_ok", ok, 1'b0);
        check("midrst_bad_count", bad_count, 8'd0);
        check("midrst_first_bad", first_bad, 8'd0);
        run(1'b0, edges);
        check("after_rst_edges", edges, EARLY ? 27 : 27);

        // en pulses during a run are ignored.
        b = '{8'h30, 8'h01, 8'h31, 8'hFF, 8'h32};
        load(5, b);
        run(1'b1, edges);
        check("glitch_first_bad", first_bad, 8'd2);

        // en held high across DONE: back-to-back runs with one IDLE cycle between.
        b = '{8'h01, 8'h7A};
        load(2, b);
        begin
            int base, waited;
            base = runs_started;
            waited = 0;
            @(negedge clk);
            en = 1'b1;
            while (runs_started < base + 2 && waited < LIMIT) begin
                @(negedge clk);
                waited++;
            end
            en = 1'b0;
            check("b2b_runs", runs_started - base, 2);
            waited = 0;
            while (!rdy && waited < LIMIT) begin
                @(negedge clk);
                waited++;
            end
            check("b2b_done", rdy, 1'b1);
        end

        // Randomised messages with stray en pulses.
        for (int r = 0; r < 25; r++) begin
            int mlen;
            mlen = $urandom_range(0, 30);
            mem[0] = 8'(mlen);
            for (int i = 1; i <= mlen; i++) begin
                if ($urandom_range(0, 9) < 8) mem[i] = 8'($urandom_range(32, 126));
                else mem[i] = 8'($urandom_range(0, 255));
            end
            run(r % 2 == 1, edges);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pt_check.md
# pt_check

Scans the length-prefixed plaintext memory that the PRGA block fills and reports whether every message byte is printable ASCII (0x20..0x7E inclusive). It is the reader at the far end of the plaintext memory. The key-search controller uses it to decide whether a candidate key produced readable text. It shares the plaintext RAM's read port and uses the same en/rdy start handshake as the other RC4 sub-blocks.

## Interface
- No parameters.
- clk  in  1  single clock; everything samples on the rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  start request; acted on only while rdy=1
- rdy  out  1  high in IDLE; block accepts en
- pt_addr  out  8  read address into the plaintext RAM
- pt_rddata  in  8  RAM read data; synchronous RAM, valid the cycle after the address is presented
- ok  out  1  1 when the last run found no bad bytes
- bad_count  out  8  number of bad bytes counted in the last run
- first_bad  out  8  address (1..255) of the first bad byte; 0 if there is none

## Operation
- Memory format:
  - Address 0 holds mlen.
  - Message bytes sit at addresses 1..mlen.
  - A byte b is bad when b<0x20 or b>0x7E.
- States: IDLE, RDLEN1, RDLEN2, RDB1, RDB2, CHECK, DONE.
- IDLE:
  - rdy=1.
  - en=1 → RDLEN1; clear k to 1, bad_count to 0, first_bad to 0, ok to 0.
- RDLEN1: pt_addr=0 → RDLEN2.
- RDLEN2:
  - pt_addr=0; capture mlen from pt_rddata.
  - mlen==0 → DONE; otherwise → RDB1.
- RDB1: pt_addr=k → RDB2.
- RDB2: pt_addr=k; capture byte.
- CHECK:
  - Classify the captured byte. If bad: bad_count+1, and first_bad=k if first_bad==0.
  - If k==mlen (or the early-exit condition holds, see Configuration) → DONE.
  - Otherwise k+1 → RDB1.
- DONE: ok ← (bad_count==0), evaluated after any CHECK update → IDLE.
- pt_addr=0 in every state not listed above.
- The block is read-only and never writes the RAM.
- Arithmetic:
  - k is 8 bits and cannot wrap, because the loop exits at k==mlen≤255.
  - bad_count is 8 bits and cannot overflow, because it is at most mlen.
- en while rdy=0 is ignored.
- Results hold from DONE until the next accepted en.

## Timing
- Reset values: rdy=1 (state IDLE), ok=0, bad_count=0, first_bad=0, pt_addr=0.
- Reset applied mid-run: the block is in IDLE on the next edge with the reset values; the partial result is discarded.
- en is sampled at edge E0. rdy returns high after edge E(3+3·N):
  - N=mlen for a full scan.
  - N=m (index of the first bad byte) when early exit fires.
  - mlen=0: rdy is high again 3 edges after E0.
- ok, bad_count and first_bad are final when rdy rises.
- bad_count and first_bad may change during a run. ok stays 0 until DONE.
- Back-to-back runs: en held high while in IDLE starts the next run immediately. There is one IDLE cycle between runs.
- Memory read: the address is held for 2 cycles, and data is captured in the second cycle.

## Configuration
- PT_CHECK_EARLY_EXIT_EN
  - Defined: CHECK goes to DONE on the first bad byte. On failure, bad_count=1, first_bad=that address and ok=0.
  - Undefined: every byte 1..mlen is always read. bad_count is the total number of bad bytes.
  - Passing runs behave identically in both builds.

## Test plan
- Reset, then idle: rdy=1, ok=0, bad_count=0, first_bad=0, pt_addr=0. en with RAM[0]=0 → rdy high 3 edges later, ok=1, bad_count=0.
- RAM = {3,'a','b','c'}, pulse en → addresses 0,1,2,3 are read. After 12 edges: rdy=1, ok=1, bad_count=0, first_bad=0.
- RAM = {4,'A',0x0A,'B',0x7F}, no macro → after 15 edges: ok=0, bad_count=2, first_bad=2. With the macro → after 9 edges: ok=0, bad_count=1, first_bad=2.
- Boundaries: bytes 0x1F, 0x20, 0x7E, 0x7F at addresses 1..4 → only 1 and 4 are flagged; first_bad=1. mlen=255, all 'x' → ok=1, last address read is 255, k does not wrap.
- Assert rst_n=0 for one cycle during RDB2 of byte 5 → IDLE with reset values on the next edge. A fresh en runs normally.
- Pulse en during a run → ignored, and the run's result is unchanged. Hold en high across DONE → a second run starts from the IDLE cycle and its results are cleared at its start.
